pp_row_accumulator_43x43: RTL and testbench

- Consumes one flattened 43x43 partial-product matrix (43 rows of 86 bits, 3698 bits total) and reduces it to the 86-bit product by accumulating ROWS_PER_CYCLE rows per clock.
- Sits directly downstream of the AND partial-product generator in the 40x40-class multiplier datapath.
- Provides a valid/ready handshake on input and output.
- Processes one matrix at a time; no overlap between jobs.

---
 rtl/pp_row_accumulator_43x43.sv | 122 ++++++++++++
 tb/tb_pp_row_accumulator_43x43.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pp_row_accumulator_43x43.sv
// rtl/pp_row_accumulator_43x43.sv - reduces a flattened partial-product matrix to its product
// Accumulates ROWS_PER_CYCLE rows per clock; one matrix in flight at a time.
module pp_row_accumulator_43x43 #(
    parameter int ROWS           = 43,
    parameter int ROW_W          = 86,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*ROW_W-1:0] in_pp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_W-1:0]      out_prod,
    output logic                  busy
);
    // Index must reach ROWS-1+ROWS_PER_CYCLE without wrapping so the last-beat test stays exact.
    localparam int IDX_W = $clog2(ROWS + ROWS_PER_CYCLE + 1);
    localparam int SEL_W = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] mat_q [ROWS];
    logic [ROW_W-1:0] mat_d [ROWS];
    logic [ROW_W-1:0] acc_q, acc_d;
    logic [ROW_W-1:0] out_prod_q, out_prod_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ROW_W-1:0] beat_sum;
    logic [IDX_W-1:0] row_sel;
    logic [IDX_W-1:0] next_idx;
    logic             last_beat;
    logic             accept;

    assign next_idx  = row_idx_q + IDX_W'(ROWS_PER_CYCLE);
    assign last_beat = next_idx >= IDX_W'(ROWS);
    assign accept    = in_valid && in_ready_q;

    // Rows past the end are masked so the final beat may be short.
    always_comb begin
        beat_sum = '0;
        row_sel  = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            row_sel = row_idx_q + IDX_W'(k);
            if (row_sel < IDX_W'(ROWS)) begin
                beat_sum = beat_sum + mat_q[row_sel[SEL_W-1:0]];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        row_idx_d  = row_idx_q;
        mat_d      = mat_q;
        out_prod_d = out_prod_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int r = 0; r < ROWS; r++) begin
                        mat_d[r] = in_pp[r*ROW_W +: ROW_W];
                    end
                    acc_d     = '0;
                    row_idx_d = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                acc_d     = acc_q + beat_sum;
                row_idx_d = next_idx;
                if (last_beat) begin
                    out_prod_d = acc_q + beat_sum;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            row_idx_q   <= '0;
            out_prod_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                mat_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            row_idx_q   <= row_idx_d;
            out_prod_q  <= out_prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mat_q       <= mat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pp_row_accumulator_43x43.sv
// tb/tb_pp_row_accumulator_43x43.sv - scoreboard bench for pp_row_accumulator_43x43
module tb_pp_row_accumulator_43x43;
    localparam int ROWS  = 43;
    localparam int ROW_W = 86;
    localparam int PP_W  = ROWS * ROW_W;
    typedef logic [ROW_W-1:0] val_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PP_W-1:0] make_pp(input logic [42:0] a, input logic [42:0] b);
        logic [PP_W-1:0] pp = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (b[i]) pp[i*ROW_W +: ROW_W] = val_t'(a) << i;
        end
        return pp;
    endfunction

    function automatic val_t mul(input logic [42:0] a, input logic [42:0] b);
        return val_t'(a) * val_t'(b);
    endfunction

    function automatic logic [42:0] rand43();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 43'd1 << $urandom_range(0, 42);
            default: return r[42:0];
        endcase
    endfunction

    logic            d_in_valid  = 1'b0;
    logic            d_in_ready;
    logic [PP_W-1:0] d_in_pp     = '0;
    logic            d_out_valid;
    logic            d_out_ready = 1'b0;
    val_t            d_out_prod;
    logic            d_busy;

    pp_row_accumulator_43x43 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_pp     (d_in_pp),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_prod  (d_out_prod),
        .busy      (d_busy)
    );

    task automatic send(input logic [42:0] a, input logic [42:0] b, output val_t exp);
        d_in_pp    = make_pp(a, b);
        d_in_valid = 1'b1;
        exp        = mul(a, b);
        for (int i = 0; i < 100 && !d_in_ready; i++) @(negedge clk);
        check("send_ready", val_t'(d_in_ready), val_t'(1));
        @(negedge clk);
        d_in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input val_t exp);
        for (int i = 0; i < 100 && !d_out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, val_t'(d_out_valid), val_t'(1));
        check(tag, d_out_prod, exp);
        d_out_ready = 1'b1;
        @(negedge clk);
        d_out_ready = 1'b0;
        check({tag, "_drop"}, val_t'(d_out_valid), val_t'(0));
    endtask

    logic rand_go = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 43);
        localparam int NJ  = (g == 0) ? 334 : 333;
        logic            in_valid  = 1'b0;
        logic            in_ready;
        logic [PP_W-1:0] in_pp     = '0;
        logic            out_valid;
        logic            out_ready = 1'b0;
        val_t            out_prod;
        logic            busy;
        val_t            exp_q[$];
        int              rx_cnt    = 0;
        logic            fin       = 1'b0;

        pp_row_accumulator_43x43 #(.ROWS_PER_CYCLE(RPC)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_pp     (in_pp),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_prod  (out_prod),
            .busy      (busy)
        );

        initial begin : drive
            logic [42:0] a, b;
            wait (rand_go);
            @(negedge clk);
            for (int j = 0; j < NJ; j++) begin
                a = rand43();
                b = rand43();
                repeat ($urandom_range(0, 2)) @(negedge clk);
                in_pp    = make_pp(a, b);
                in_valid = 1'b1;
                exp_q.push_back(mul(a, b));
                for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
                @(negedge clk);
                in_valid = 1'b0;
            end
        end

        initial begin : monitor
            val_t exp;
            wait (rand_go);
            while (rx_cnt < NJ) begin
                @(negedge clk);
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) begin
                    check($sformatf("rand_rpc%0d_queue", RPC), val_t'(exp_q.size() != 0), val_t'(1));
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check($sformatf("rand_rpc%0d_prod", RPC), out_prod, exp);
                    end
                    rx_cnt++;
                end
            end
            @(negedge clk);
            out_ready = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin : main
        val_t e1, e2;
        int   lat;
        logic busy_ok;

        repeat (3) @(negedge clk);
        check("rst_out_valid", val_t'(d_out_valid), val_t'(0));
        check("rst_busy", val_t'(d_busy), val_t'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", val_t'(d_in_ready), val_t'(1));
        check("rst_out_prod", d_out_prod, val_t'(0));

        send(43'd0, 43'd0, e1);
        lat     = 0;
        busy_ok = 1'b1;
        while (!d_out_valid && lat < 100) begin
            if (!d_busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("zero_latency", val_t'(lat), val_t'(11));
        check("zero_busy", val_t'(busy_ok), val_t'(1));
        collect("zero_prod", val_t'(0));

        send('1, '1, e1);
        check("ones_model", e1, 86'h3FFFFFFFFFF00000000001);
        collect("ones_prod", 86'h3FFFFFFFFFF00000000001);

        send(43'd1, 43'd1 << 42, e1);
        collect("row42_prod", val_t'(1) << 42);

        send(43'h123456789AB, 43'h7EDCBA98765, e1);
        for (int i = 0; i < 100 && !d_out_valid; i++) @(negedge clk);
        d_in_pp    = make_pp(43'h5A5A5A5A5A5, 43'h0F0F0F0F0F0);
        d_in_valid = 1'b1;
        e2         = mul(43'h5A5A5A5A5A5, 43'h0F0F0F0F0F0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_prod", d_out_prod, e1);
            check("stall_in_ready", val_t'(d_in_ready), val_t'(0));
            check("stall_out_valid", val_t'(d_out_valid), val_t'(1));
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        d_out_ready = 1'b0;
        check("stall_once", val_t'(d_out_valid), val_t'(0));
        check("stall_idle_ready", val_t'(d_in_ready), val_t'(1));
        @(negedge clk);
        d_in_valid = 1'b0;
        check("stall_accepted", val_t'(d_busy), val_t'(1));
        collect("stall_second", e2);

        send(43'h3FF00FF00FF, 43'h2AAAAAAAAAA, e1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", val_t'(d_out_valid), val_t'(0));
        check("abort_out_prod", d_out_prod, val_t'(0));
        check("abort_busy", val_t'(d_busy), val_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", val_t'(d_in_ready), val_t'(1));
        check("abort_no_emit", val_t'(d_out_valid), val_t'(0));
        send(43'd3, 43'd5, e1);
        collect("after_abort", val_t'(15));

        rand_go = 1'b1;
        for (int i = 0; i < 80000 && !(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin); i++) begin
            @(negedge clk);
        end
        check("rand_rpc1_done", val_t'(g_rand[0].rx_cnt), val_t'(334));
        check("rand_rpc4_done", val_t'(g_rand[1].rx_cnt), val_t'(333));
        check("rand_rpc43_done", val_t'(g_rand[2].rx_cnt), val_t'(333));
        check("rand_rpc1_drained", val_t'(g_rand[0].exp_q.size()), val_t'(0));
        check("rand_rpc4_drained", val_t'(g_rand[1].exp_q.size()), val_t'(0));
        check("rand_rpc43_drained", val_t'(g_rand[2].exp_q.size()), val_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
